// File: rtl/if_fetch_queue.sv
// if_fetch_queue
// Instruction fetch front end for the 5-stage RV32 pipeline. Owns the fetch
// PC, issues sequential word reads to a synchronous-read instruction SRAM,
// buffers returned words in a DEPTH-entry prefetch FIFO and hands one
// {pc, instr} pair per cycle to decode under valid/ready.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   im_req/im_addr  SRAM read request and word address (data next cycle)
//   im_rdata        SRAM read data, valid one cycle after im_req
//   redirect_*      flush everything and restart fetch at redirect_pc
//   out_valid/ready decode handshake on the FIFO head
//   out_pc/pc4      head PC and head PC + 4 (0 / 4 when empty)
//   out_instr       head instruction (NOP when empty)
module if_fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        im_req,
   output logic [31:0] im_addr,
   input  logic [31:0] im_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_pc4,
   output logic [31:0] out_instr
);

   localparam int          PTR_W = $clog2(DEPTH);
   localparam int          CNT_W = PTR_W + 1;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   logic [31:0]      fetch_pc_q, fetch_pc_d;
   logic             inflight_q, inflight_d;
   logic [31:0]      inflight_pc_q, inflight_pc_d;
   entry_t           fifo_q [DEPTH];
   entry_t           fifo_d [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic             head_vld;
   logic             pop;
   logic             push;
   logic [CNT_W:0]   credit;

   always_comb begin
      head_vld = !rst && (count_q != '0);
      // A redirect flushes the head, so a same-cycle pop is dropped.
      pop      = head_vld && out_ready && !redirect_valid;
      push     = !rst && !redirect_valid && inflight_q;
      // Occupancy the FIFO will reach once the in-flight word lands; issuing
      // only while this is below DEPTH means a push never sees a full FIFO.
      credit   = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, pop};
      im_req   = !rst && !redirect_valid && (credit < (CNT_W+1)'(DEPTH));
      im_addr  = rst ? RESET_PC : fetch_pc_q;

      fetch_pc_d    = fetch_pc_q;
      inflight_d    = inflight_q;
      inflight_pc_d = inflight_pc_q;
      fifo_d        = fifo_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      count_d       = count_q;

      if (redirect_valid) begin
         // The response arriving now belongs to the old stream: drop it.
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
         inflight_d = 1'b0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (push) begin
            fifo_d[wr_ptr_q] = '{pc: inflight_pc_q, instr: im_rdata};
            wr_ptr_d         = wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
         count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
         inflight_d = im_req;
         if (im_req) begin
            inflight_pc_d = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + 32'd4;
         end
      end
   end

   // Outputs come only from FIFO registers; no bypass from im_rdata.
   always_comb begin
      out_valid = head_vld;
      out_pc    = head_vld ? fifo_q[rd_ptr_q].pc    : 32'h0;
      out_instr = head_vld ? fifo_q[rd_ptr_q].instr : NOP;
      out_pc4   = out_pc + 32'd4;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q    <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= 32'h0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
         for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
         for (int i = 0; i < DEPTH; i++) fifo_q[i] <= fifo_d[i];
      end
   end

endmodule
